bounce_sprite: RTL and testbench

Screensaver motion engine: holds the top-left origin of a rectangular sprite, advances it once per video frame, and reflects it off the screen edges in the classic bouncing-logo style. Sits between the video timer and the image stage. It consumes the timer's frame counter and next-pixel coordinates, and produces a registered "pixel is inside sprite" flag plus a colour index that the image stage uses to draw. Bounce and corner events are exported for status and debug.

---
 rtl/bounce_sprite.sv | 232 +++++++++++++++++++++++
 tb/tb_bounce_sprite.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bounce_sprite.sv
`default_nettype none
// ============================================================================
// Module      : bounce_sprite
// Description : Bouncing-sprite motion engine. Holds the top-left origin of a
//               rectangular sprite and advances it once per video frame. The
//               sprite reflects off the screen edges. The module also
//               produces a registered "pixel inside sprite" flag for the
//               image stage and a colour index that changes on each bounce.
//
// Ports       : clk_25_175      in   pixel clock (only clock)
//               rst             in   synchronous, active-high reset
//               frame[31:0]     in   frame counter from the video timer
//               position_x_NEXT in   x coordinate of the next pixel
//               position_y_NEXT in   y coordinate of the next pixel
//               sprite_x[9:0]   out  current x origin
//               sprite_y[8:0]   out  current y origin
//               hit             out  registered: next pixel lies inside sprite
//               hue[2:0]        out  sprite colour index
//               bounce          out  one-cycle pulse when any wall is struck
//               corner          out  one-cycle pulse when both axes strike
//
// Options     : CORNER_FLASH_EN - when defined, a corner event forces hue to 7
//               for 59 steps while the internal hue counter keeps running.
//
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_sprite #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SPRITE_W = 64,
    parameter int SPRITE_H = 32,
    parameter int SPEED_X  = 1,
    parameter int SPEED_Y  = 1,
    parameter int START_X  = 0,
    parameter int START_Y  = 0
) (
    input  logic        clk_25_175,
    input  logic        rst,
    input  logic [31:0] frame,
    input  logic [9:0]  position_x_NEXT,
    input  logic [8:0]  position_y_NEXT,
    output logic [9:0]  sprite_x,
    output logic [8:0]  sprite_y,
    output logic        hit,
    output logic [2:0]  hue,
    output logic        bounce,
    output logic        corner
);

    // Arithmetic is done one bit wider than the coordinate so that the
    // overshoot past the far edge is visible before clamping.
    localparam logic [10:0] C_X_MAX    = 11'(SCREEN_W - SPRITE_W);
    localparam logic [9:0]  C_Y_MAX    = 10'(SCREEN_H - SPRITE_H);
    localparam logic [10:0] C_SPEED_X  = 11'(SPEED_X);
    localparam logic [9:0]  C_SPEED_Y  = 10'(SPEED_Y);
    localparam logic [10:0] C_SPRITE_W = 11'(SPRITE_W);
    localparam logic [9:0]  C_SPRITE_H = 10'(SPRITE_H);
    localparam logic [9:0]  C_START_X  = 10'(START_X);
    localparam logic [8:0]  C_START_Y  = 9'(START_Y);

    typedef enum logic [0:0] {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    dir_t        r_x_dir;
    dir_t        r_y_dir;
    dir_t        w_x_dir_next;
    dir_t        w_y_dir_next;

    logic [31:0] r_frame_q;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [2:0]  r_hue;
    logic        r_hit;
    logic        r_bounce;
    logic        r_corner;

    logic        w_step;
    logic [10:0] w_x_sum;
    logic [9:0]  w_y_sum;
    logic [9:0]  w_x_next;
    logic [8:0]  w_y_next;
    logic        w_x_wall;
    logic        w_y_wall;
    logic [10:0] w_x_end;
    logic [9:0]  w_y_end;
    logic        w_in_x;
    logic        w_in_y;

    // Any difference counts, so wraps and multi-frame jumps each give one step.
    assign w_step  = (frame != r_frame_q);

    assign w_x_sum = {1'b0, r_x} + C_SPEED_X;
    assign w_y_sum = {1'b0, r_y} + C_SPEED_Y;

    // ------------------------------------------------------------------
    // X axis next-state / next-position
    // ------------------------------------------------------------------
    always_comb begin
        w_x_next     = r_x;
        w_x_dir_next = r_x_dir;
        w_x_wall     = 1'b0;
        if (w_step) begin
            case (r_x_dir)
                DIR_POS: begin
                    if (w_x_sum >= C_X_MAX) begin
                        w_x_next     = C_X_MAX[9:0];
                        w_x_dir_next = DIR_NEG;
                        w_x_wall     = 1'b1;
                    end else begin
                        w_x_next = w_x_sum[9:0];
                    end
                end
                DIR_NEG: begin
                    if ({1'b0, r_x} <= C_SPEED_X) begin
                        w_x_next     = 10'd0;
                        w_x_dir_next = DIR_POS;
                        w_x_wall     = 1'b1;
                    end else begin
                        w_x_next = r_x - C_SPEED_X[9:0];
                    end
                end
                default: begin
                    w_x_dir_next = DIR_POS;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Y axis next-state / next-position
    // ------------------------------------------------------------------
    always_comb begin
        w_y_next     = r_y;
        w_y_dir_next = r_y_dir;
        w_y_wall     = 1'b0;
        if (w_step) begin
            case (r_y_dir)
                DIR_POS: begin
                    if (w_y_sum >= C_Y_MAX) begin
                        w_y_next     = C_Y_MAX[8:0];
                        w_y_dir_next = DIR_NEG;
                        w_y_wall     = 1'b1;
                    end else begin
                        w_y_next = w_y_sum[8:0];
                    end
                end
                DIR_NEG: begin
                    if ({1'b0, r_y} <= C_SPEED_Y) begin
                        w_y_next     = 9'd0;
                        w_y_dir_next = DIR_POS;
                        w_y_wall     = 1'b1;
                    end else begin
                        w_y_next = r_y - C_SPEED_Y[8:0];
                    end
                end
                default: begin
                    w_y_dir_next = DIR_POS;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sprite window test against the next pixel
    // ------------------------------------------------------------------
    assign w_x_end = {1'b0, r_x} + C_SPRITE_W;
    assign w_y_end = {1'b0, r_y} + C_SPRITE_H;
    assign w_in_x  = (position_x_NEXT >= r_x) && ({1'b0, position_x_NEXT} < w_x_end);
    assign w_in_y  = (position_y_NEXT >= r_y) && ({1'b0, position_y_NEXT} < w_y_end);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25_175) begin
        if (rst) begin
            // Loading the live frame value means the first cycle out of
            // reset never sees a spurious change.
            r_frame_q <= frame;
            r_x       <= C_START_X;
            r_y       <= C_START_Y;
            r_x_dir   <= DIR_POS;
            r_y_dir   <= DIR_POS;
            r_hue     <= 3'd0;
            r_hit     <= 1'b0;
            r_bounce  <= 1'b0;
            r_corner  <= 1'b0;
        end else begin
            r_frame_q <= frame;
            r_x       <= w_x_next;
            r_y       <= w_y_next;
            r_x_dir   <= w_x_dir_next;
            r_y_dir   <= w_y_dir_next;
            r_hit     <= w_in_x && w_in_y;
            r_bounce  <= w_x_wall | w_y_wall;
            r_corner  <= w_x_wall & w_y_wall;
            // A corner advances the hue only once.
            if (w_x_wall | w_y_wall) begin
                r_hue <= r_hue + 3'd1;
            end
        end
    end

`ifdef CORNER_FLASH_EN
    logic [5:0] r_flash;

    always_ff @(posedge clk_25_175) begin
        if (rst) begin
            r_flash <= 6'd0;
        end else if (w_step) begin
            if (w_x_wall & w_y_wall) begin
                r_flash <= 6'd59;
            end else if (r_flash != 6'd0) begin
                r_flash <= r_flash - 6'd1;
            end
        end
    end

    assign hue = (r_flash != 6'd0) ? 3'd7 : r_hue;
`else
    assign hue = r_hue;
`endif

    assign sprite_x = r_x;
    assign sprite_y = r_y;
    assign hit      = r_hit;
    assign bounce   = r_bounce;
    assign corner   = r_corner;

endmodule
`default_nettype wire

// File: tb/tb_bounce_sprite.sv
`default_nettype none
// ============================================================================
// Module      : tb_bounce_sprite
// Description : Directed self-checking bench for bounce_sprite. Five DUT
//               instances with different parameters share clock, reset,
//               frame counter and pixel coordinates:
//                 0 def  : all defaults
//                 1 hit  : origin 100,50 (window test, never stepped first)
//                 2 rw   : START_X=574, SPEED_X=2 (right wall)
//                 3 lw   : SCREEN_W=67, START_X=3, SPEED_X=2 (left wall)
//                 4 cor  : START_X=575, START_Y=447 (corner / flash)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bounce_sprite;

`ifdef CORNER_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] frame;
    logic [9:0]  px;
    logic [8:0]  py;

    logic [9:0]  sx [5];
    logic [8:0]  sy [5];
    logic        ht [5];
    logic [2:0]  hu [5];
    logic        bo [5];
    logic        co [5];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #20 clk = ~clk;

    bounce_sprite u_def (
        .clk_25_175(clk), .rst(rst), .frame(frame),
        .position_x_NEXT(px), .position_y_NEXT(py),
        .sprite_x(sx[0]), .sprite_y(sy[0]), .hit(ht[0]), .hue(hu[0]),
        .bounce(bo[0]), .corner(co[0])
    );

    bounce_sprite #(.START_X(100), .START_Y(50)) u_hit (
        .clk_25_175(clk), .rst(rst), .frame(frame),
        .position_x_NEXT(px), .position_y_NEXT(py),
        .sprite_x(sx[1]), .sprite_y(sy[1]), .hit(ht[1]), .hue(hu[1]),
        .bounce(bo[1]), .corner(co[1])
    );

    bounce_sprite #(.START_X(574), .SPEED_X(2)) u_rw (
        .clk_25_175(clk), .rst(rst), .frame(frame),
        .position_x_NEXT(px), .position_y_NEXT(py),
        .sprite_x(sx[2]), .sprite_y(sy[2]), .hit(ht[2]), .hue(hu[2]),
        .bounce(bo[2]), .corner(co[2])
    );

    bounce_sprite #(.SCREEN_W(67), .START_X(3), .SPEED_X(2)) u_lw (
        .clk_25_175(clk), .rst(rst), .frame(frame),
        .position_x_NEXT(px), .position_y_NEXT(py),
        .sprite_x(sx[3]), .sprite_y(sy[3]), .hit(ht[3]), .hue(hu[3]),
        .bounce(bo[3]), .corner(co[3])
    );

    bounce_sprite #(.START_X(575), .START_Y(447)) u_cor (
        .clk_25_175(clk), .rst(rst), .frame(frame),
        .position_x_NEXT(px), .position_y_NEXT(py),
        .sprite_x(sx[4]), .sprite_y(sy[4]), .hit(ht[4]), .hue(hu[4]),
        .bounce(bo[4]), .corner(co[4])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Change the frame counter at a falling edge; outputs are sampled at the
    // following falling edge, i.e. in the cycle after the step.
    task automatic step(input logic [31:0] nf);
        @(negedge clk);
        frame = nf;
        @(negedge clk);
    endtask

    task automatic hit_probe(input string tag, input logic [9:0] x, input logic [8:0] y,
                             input logic exp);
        @(negedge clk);
        px = x;
        py = y;
        @(negedge clk);
        check(tag, {31'd0, ht[1]}, {31'd0, exp});
    endtask

    initial begin
        logic [31:0] nf;
        logic [2:0]  exp_hue;

        rst   = 1'b1;
        frame = 32'd5;
        px    = 10'd639;
        py    = 9'd479;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset values
        check("rst_def_x",   {22'd0, sx[0]}, 32'd0);
        check("rst_def_y",   {23'd0, sy[0]}, 32'd0);
        check("rst_def_hue", {29'd0, hu[0]}, 32'd0);
        check("rst_def_hit", {31'd0, ht[0]}, 32'd0);
        check("rst_def_bnc", {31'd0, bo[0]}, 32'd0);
        check("rst_def_cor", {31'd0, co[0]}, 32'd0);
        check("rst_rw_x",    {22'd0, sx[2]}, 32'd574);
        check("rst_cor_x",   {22'd0, sx[4]}, 32'd575);
        check("rst_cor_y",   {23'd0, sy[4]}, 32'd447);
        check("rst_hit_x",   {22'd0, sx[1]}, 32'd100);

        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Frame held constant: nothing moves
        check("nostep_x",   {22'd0, sx[0]}, 32'd0);
        check("nostep_y",   {23'd0, sy[0]}, 32'd0);
        check("nostep_bnc", {31'd0, bo[0]}, 32'd0);

        // Hit window on sprite at 100,50 (64x32)
        hit_probe("hit_99_50",   10'd99,  9'd50, 1'b0);
        hit_probe("hit_100_50",  10'd100, 9'd50, 1'b1);
        hit_probe("hit_163_81",  10'd163, 9'd81, 1'b1);
        hit_probe("hit_164_81",  10'd164, 9'd81, 1'b0);
        hit_probe("hit_163_82",  10'd163, 9'd82, 1'b0);
        px = 10'd639;
        py = 9'd479;

        // Step 1
        step(32'd6);
        check("s1_def_x",   {22'd0, sx[0]}, 32'd1);
        check("s1_def_bnc", {31'd0, bo[0]}, 32'd0);
        check("s1_rw_x",    {22'd0, sx[2]}, 32'd576);
        check("s1_rw_bnc",  {31'd0, bo[2]}, 32'd1);
        check("s1_rw_hue",  {29'd0, hu[2]}, 32'd1);
        check("s1_rw_cor",  {31'd0, co[2]}, 32'd0);
        check("s1_lw_x",    {22'd0, sx[3]}, 32'd3);
        check("s1_lw_bnc",  {31'd0, bo[3]}, 32'd1);
        check("s1_cor_x",   {22'd0, sx[4]}, 32'd576);
        check("s1_cor_y",   {23'd0, sy[4]}, 32'd448);
        check("s1_cor_cor", {31'd0, co[4]}, 32'd1);
        check("s1_cor_bnc", {31'd0, bo[4]}, 32'd1);
        check("s1_cor_hue", {29'd0, hu[4]}, FLASH ? 32'd7 : 32'd1);
        @(negedge clk);
        check("pulse_bnc_off", {31'd0, bo[4]}, 32'd0);
        check("pulse_cor_off", {31'd0, co[4]}, 32'd0);

        // Step 2: both reflected axes move back
        step(32'd7);
        check("s2_rw_x",    {22'd0, sx[2]}, 32'd574);
        check("s2_rw_bnc",  {31'd0, bo[2]}, 32'd0);
        check("s2_rw_hue",  {29'd0, hu[2]}, 32'd1);
        check("s2_lw_x",    {22'd0, sx[3]}, 32'd1);
        check("s2_cor_x",   {22'd0, sx[4]}, 32'd575);
        check("s2_cor_y",   {23'd0, sy[4]}, 32'd447);
        check("s2_cor_hue", {29'd0, hu[4]}, FLASH ? 32'd7 : 32'd1);

        // Step 3: left wall from x=1 with speed 2
        step(32'd8);
        check("s3_lw_x",    {22'd0, sx[3]}, 32'd0);
        check("s3_lw_bnc",  {31'd0, bo[3]}, 32'd1);
        check("s3_lw_hue",  {29'd0, hu[3]}, 32'd2);

        // Step 4: back in POS
        step(32'd9);
        check("s4_lw_x",    {22'd0, sx[3]}, 32'd2);
        check("s4_lw_bnc",  {31'd0, bo[3]}, 32'd0);
        check("s4_def_x",   {22'd0, sx[0]}, 32'd4);

        // Long run: frame wrap, frame jump, corner flash window
        for (int k = 5; k <= 62; k++) begin
            if (k == 20)      nf = 32'hFFFF_FFFF;
            else if (k == 21) nf = 32'd0;
            else if (k == 30) nf = frame + 32'd7;
            else              nf = frame + 32'd1;
            step(nf);
            exp_hue = (FLASH && (k <= 59)) ? 3'd7 : 3'd1;
            check($sformatf("run%0d_def_x", k), {22'd0, sx[0]}, k);
            check($sformatf("run%0d_cor_hue", k), {29'd0, hu[4]}, {29'd0, exp_hue});
        end

        // Reset coinciding with a frame change wins
        @(negedge clk);
        frame = frame + 32'd1;
        rst   = 1'b1;
        @(negedge clk);
        check("mid_rst_x",   {22'd0, sx[0]}, 32'd0);
        check("mid_rst_hue", {29'd0, hu[4]}, 32'd0);
        check("mid_rst_cx",  {22'd0, sx[4]}, 32'd575);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_x",  {22'd0, sx[0]}, 32'd0);
        check("post_rst_bnc",{31'd0, bo[4]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
